lut_layer_sequencer: RTL and testbench
======================================

Name: lut_layer_sequencer

Overview:
- Time-multiplexed evaluator for one quantised layer of FANIN-input, 1-bit-output truth-table neurons.
- Holds one 2^FANIN-bit truth table per neuron in a distributed register file, loaded over a config port.
- Per accepted input vector, looks up one neuron per cycle and returns the packed layer output over a valid/ready handshake.
- Sits between layer N-1 output registers and layer N+1 input; replaces NEURONS parallel LUT instances where area matters more than throughput.

Parameters:
- NEURONS, 8, neurons in the layer (2..64).
- FANIN, 6, input bits per neuron; truth-table depth 2^FANIN.
- IDX_W, $clog2(NEURONS), neuron index width (derived, not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  sequencer can accept a vector.
- in_bits  in  NEURONS*FANIN  neuron k's address = in_bits[k*FANIN +: FANIN].
- out_valid  out  1  out_bits valid.
- out_ready  in  1  downstream accepts.
- out_bits  out  NEURONS  bit k = neuron k result.
- cfg_we  in  1  truth-table write strobe.
- cfg_ready  out  1  config write accepted this cycle.
- cfg_idx  in  IDX_W  neuron to write.
- cfg_tt  in  2^FANIN  truth table; bit a = output for address a.
- busy  out  1  high in RUN.

Behaviour:
- Reset (async assert, sync release): state IDLE, idx 0, all truth tables 0, out_bits 0, out_valid 0, busy 0. in_ready and cfg_ready are combinational and read 1 in IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid, capture in_bits into an internal register, clear out_bits, set idx=0, go to RUN.
- RUN: busy=1, in_ready=0. Each cycle: out_bits[idx] <= tt[idx][addr(idx)], where addr comes from the captured vector. idx increments. When idx=NEURONS-1 the write completes and the FSM goes to DONE.
- DONE: out_valid=1, and out_bits is held stable while out_valid && !out_ready.
  - On out_ready: out_valid drops next cycle.
  - in_ready = out_ready, so a new vector can be accepted in the same cycle and the FSM goes directly to RUN (back-to-back).
  - Otherwise the FSM goes to IDLE.
- Latency: vector accepted at edge T; out_valid high after edge T+NEURONS. Throughput is one vector per NEURONS+1 cycles with out_ready tied high.
- Config:
  - cfg_ready = (state != RUN).
  - A write occurs on cfg_we && cfg_ready: tt[cfg_idx] <= cfg_tt at that edge.
  - cfg_we during RUN is dropped, with no queuing.
  - cfg_idx >= NEURONS is ignored.
- Simultaneous events:
  - A config write in the same cycle as input acceptance in IDLE takes effect before any lookup of that vector.
  - A config write in DONE does not alter the held out_bits.
- rst_n low mid-RUN aborts the vector, drops out_valid, and clears truth tables. Software must reload the tables.
- in_bits changes after acceptance have no effect on the result.

Optional Feature:
- Macro: LUT_SEQ_PIPE_EN.
- Defined:
  - Adds a register stage between the address/table-row select and the output-bit write.
  - Out_bits[k] is written one cycle after neuron k is issued, and RUN lasts NEURONS+1 cycles.
  - out_valid rises after edge T+NEURONS+1.
  - cfg_ready also stays low during the drain cycle.
- Undefined: single-stage lookup, timing as in Behaviour.

Test Plan:
- Default params, reset only -> out_valid=0, in_ready=1, cfg_ready=1, out_bits=8'h00. Any vector afterwards returns 8'h00 (all tables zero).
- Load tt[k]=64'h1 for all k. Send in_bits with every slice 6'd0 -> out_bits=8'hFF, out_valid after edge T+8. Repeat with slice 3 = 6'd5 -> out_bits=8'hF7.
- Load tt[2]=64'h8000_0000_0000_0000. Set neuron 2 slice=6'd63 and the others to 0 -> out_bits bit 2 =1. Hold out_ready=0 for 5 cycles -> out_bits stable and out_valid held high.
- With out_ready tied 1 and in_valid tied 1, stream 3 vectors -> outputs spaced exactly 9 cycles apart, no lost vectors.
- Assert cfg_we at RUN cycle 3 -> cfg_ready=0, table unchanged, result matches the old table. Pulse rst_n low at RUN cycle 4 -> out_valid=0, state IDLE, tables zeroed.
- LUT_SEQ_PIPE_EN defined, same vector as scenario 2 -> identical out_bits, out_valid one cycle later (edge T+9).

Source files
------------

// File: rtl/lut_layer_sequencer_if.sv
// Handshake, result and truth-table config bundle for lut_layer_sequencer.
// The sequencer itself connects through the slave modport.
interface lut_layer_sequencer_if #(
  parameter  int NEURONS = 8,
  parameter  int FANIN   = 6,
  localparam int IDX_W   = $clog2(NEURONS)
);
  logic                      in_valid;
  logic                      in_ready;
  logic [NEURONS*FANIN-1:0]  in_bits;
  logic                      out_valid;
  logic                      out_ready;
  logic [NEURONS-1:0]        out_bits;
  logic                      cfg_we;
  logic                      cfg_ready;
  logic [IDX_W-1:0]          cfg_idx;
  logic [(1<<FANIN)-1:0]     cfg_tt;
  logic                      busy;

  modport master (
    output in_valid, in_bits, out_ready, cfg_we, cfg_idx, cfg_tt,
    input  in_ready, out_valid, out_bits, cfg_ready, busy
  );

  modport slave (
    input  in_valid, in_bits, out_ready, cfg_we, cfg_idx, cfg_tt,
    output in_ready, out_valid, out_bits, cfg_ready, busy
  );
endinterface

// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed truth-table layer: one neuron lookup per cycle per accepted vector.
// Define LUT_SEQ_PIPE_EN to register the table read before the output-bit write.
module lut_layer_sequencer #(
  parameter  int NEURONS = 8,
  parameter  int FANIN   = 6,
  localparam int IDX_W   = $clog2(NEURONS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lut_layer_sequencer_if.slave  bus
);
  localparam int               TT_W     = 1 << FANIN;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURONS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state;
  logic [IDX_W-1:0]         idx;
  logic [NEURONS*FANIN-1:0] vec;
  logic [TT_W-1:0]          tt [NEURONS];
  logic [NEURONS-1:0]       out_bits_q;
  logic                     out_valid_q;
  logic                     busy_q;

  logic                     in_ready_c;
  logic                     cfg_ready_c;
  logic                     accept;
  logic [FANIN-1:0]         addr;
  logic                     lut_bit;

`ifdef LUT_SEQ_PIPE_EN
  logic                     issuing;
  logic                     pipe_v;
  logic                     pipe_bit;
  logic [IDX_W-1:0]         pipe_idx;
`endif

  always_comb begin
    in_ready_c  = (state == IDLE) || (state == DONE && bus.out_ready);
    cfg_ready_c = (state != RUN);
    accept      = bus.in_valid && in_ready_c;
    addr        = vec[int'(idx)*FANIN +: FANIN];
    lut_bit     = tt[idx][addr];
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.cfg_ready = cfg_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bits  = out_bits_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      vec         <= '0;
      out_bits_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int unsigned k = 0; k < NEURONS; k++) tt[k] <= '0;
`ifdef LUT_SEQ_PIPE_EN
      issuing     <= 1'b0;
      pipe_v      <= 1'b0;
      pipe_bit    <= 1'b0;
      pipe_idx    <= '0;
`endif
    end else begin
      if (bus.cfg_we && cfg_ready_c && int'(bus.cfg_idx) < NEURONS)
        tt[bus.cfg_idx] <= bus.cfg_tt;

      unique case (state)
        IDLE, DONE: begin
          if (state == DONE && bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
          // Acceptance overrides the DONE->IDLE move for back-to-back vectors.
          if (accept) begin
            vec        <= bus.in_bits;
            out_bits_q <= '0;
            idx        <= '0;
            busy_q     <= 1'b1;
            state      <= RUN;
`ifdef LUT_SEQ_PIPE_EN
            issuing    <= 1'b1;
            pipe_v     <= 1'b0;
`endif
          end
        end
        RUN: begin
`ifdef LUT_SEQ_PIPE_EN
          pipe_v   <= issuing;
          pipe_idx <= idx;
          pipe_bit <= lut_bit;
          if (issuing) begin
            if (idx == LAST_IDX) issuing <= 1'b0;
            else                 idx     <= idx + 1'b1;
          end
          // RUN ends when the last issued neuron drains out of the stage.
          if (pipe_v) begin
            out_bits_q[pipe_idx] <= pipe_bit;
            if (pipe_idx == LAST_IDX) begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              busy_q      <= 1'b0;
            end
          end
`else
          out_bits_q[idx] <= lut_bit;
          if (idx == LAST_IDX) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Self-checking bench for lut_layer_sequencer: table vectors, random tables/vectors
// against a lookup model, and hand-written multi-cycle corner sequences.
module tb_lut_layer_sequencer;
  localparam int N  = 8;
  localparam int F  = 6;
  localparam int VW = N * F;
`ifdef LUT_SEQ_PIPE_EN
  localparam int LAT = N + 1;
`else
  localparam int LAT = N;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lut_layer_sequencer_if #(.NEURONS(N), .FANIN(F)) bus ();
  lut_layer_sequencer #(.NEURONS(N), .FANIN(F)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [63:0] tt_m [N];

  typedef struct {
    string         name;
    logic [VW-1:0] vec;
    logic [N-1:0]  exp;
  } vec_rec_t;
  vec_rec_t tbl [4];

  function automatic logic [VW-1:0] with_slice(input logic [VW-1:0] base, input int k,
                                               input logic [F-1:0] a);
    logic [VW-1:0] r;
    r = base;
    r[k*F +: F] = a;
    return r;
  endfunction

  // Neuron k answers with bit <its address> of its truth table.
  function automatic logic [N-1:0] model(input logic [VW-1:0] v);
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = tt_m[k][int'(v[k*F +: F])];
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    return VW'({$urandom, $urandom});
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cfg_write(input int k, input logic [63:0] t);
    @(negedge clk);
    check("cfg_ready_when_writing", 64'(bus.cfg_ready), 64'd1);
    bus.cfg_we  = 1'b1;
    bus.cfg_idx = 3'(k);
    bus.cfg_tt  = t;
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
    tt_m[k]    = t;
  endtask

  // Leaves the bench 1 time unit after the accepting edge T, with in_bits scrambled.
  task automatic accept(input logic [VW-1:0] v);
    @(negedge clk);
    check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_bits  = v;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_bits  = rand_vec();
  endtask

  task automatic wait_out(input string nm, input logic [N-1:0] exp, input int start);
    int lat;
    lat = start;
    while (bus.out_valid !== 1'b1 && lat < 4 * N) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({nm, "_latency"}, 64'(lat), 64'(LAT));
    check({nm, "_bits"}, 64'(bus.out_bits), 64'(exp));
  endtask

  task automatic consume();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("out_valid_drop", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [VW-1:0] v;
    logic [N-1:0]  old_res;
    logic [VW-1:0] sv [3];
    int            tout [3];
    int            acc, got, cyc;
    logic          ir;

    bus.in_valid = 1'b0; bus.in_bits = '0; bus.out_ready = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_tt = '0;
    for (int k = 0; k < N; k++) tt_m[k] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_in_ready",  64'(bus.in_ready),  64'd1);
    check("reset_cfg_ready", 64'(bus.cfg_ready), 64'd1);
    check("reset_out_bits",  64'(bus.out_bits),  64'd0);
    check("reset_busy",      64'(bus.busy),      64'd0);

    accept(rand_vec());
    check("busy_in_run", 64'(bus.busy), 64'd1);
    wait_out("zero_tables", 8'h00, 0);
    consume();

    for (int k = 0; k < N; k++) cfg_write(k, 64'h1);
    tbl[0] = '{"all_zero_addr", VW'(0), 8'hFF};
    tbl[1] = '{"slice3_is_5", with_slice('0, 3, 6'd5), 8'hF7};
    tbl[2] = '{"all_addr_1", {N{6'd1}}, 8'h00};
    tbl[3] = '{"slice0_63_slice7_2", with_slice(with_slice('0, 0, 6'd63), 7, 6'd2), 8'h7E};
    for (int i = 0; i < 4; i++) begin
      accept(tbl[i].vec);
      wait_out(tbl[i].name, tbl[i].exp, 0);
      consume();
    end

    // Top truth-table bit, then hold out_ready low; a DONE config write must not disturb out_bits.
    cfg_write(2, 64'h8000_0000_0000_0000);
    v = with_slice('0, 2, 6'd63);
    accept(v);
    wait_out("addr63", 8'hFF, 0);
    check("addr63_bit2", 64'(bus.out_bits[2]), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("cfg_ready_in_done", 64'(bus.cfg_ready), 64'd1);
        bus.cfg_we = 1'b1; bus.cfg_idx = 3'd2; bus.cfg_tt = '0;
      end
      @(posedge clk);
      #1;
      if (bus.cfg_we) tt_m[2] = '0;
      bus.cfg_we = 1'b0;
      check("hold_out_valid", 64'(bus.out_valid), 64'd1);
      check("hold_out_bits",  64'(bus.out_bits),  64'hFF);
    end
    consume();
    accept(v);
    wait_out("tt2_rewritten_in_done", model(v), 0);
    consume();

    // Config write in the same cycle as acceptance is visible to that vector.
    v = '0;
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_idx = 3'd4; bus.cfg_tt = 64'hFFFF_FFFF_FFFF_FFFE;
    bus.in_valid = 1'b1; bus.in_bits = v;
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0; bus.in_valid = 1'b0; bus.in_bits = rand_vec();
    tt_m[4] = 64'hFFFF_FFFF_FFFF_FFFE;
    wait_out("cfg_with_accept", model(v), 0);
    consume();

    for (int k = 0; k < N; k++) cfg_write(k, {$urandom, $urandom});
    for (int i = 0; i < 6; i++) begin
      v = rand_vec();
      accept(v);
      wait_out("random", model(v), 0);
      consume();
    end

    // Streaming with in_valid and out_ready held high.
    for (int i = 0; i < 3; i++) sv[i] = rand_vec();
    acc = 0; got = 0; cyc = 0;
    @(negedge clk);
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_bits = sv[0];
    while (got < 3 && cyc < 200) begin
      ir = bus.in_ready;
      @(posedge clk);
      cyc++;
      if (ir && bus.in_valid) acc++;
      #1;
      if (bus.out_valid === 1'b1) begin
        check("stream_bits", 64'(bus.out_bits), 64'(model(sv[got])));
        tout[got] = cyc;
        got++;
      end
      @(negedge clk);
      if (acc < 3) bus.in_bits = sv[acc];
      else         bus.in_valid = 1'b0;
    end
    check("stream_count", 64'(got), 64'd3);
    if (got == 3) begin
      check("stream_gap_0_1", 64'(tout[1] - tout[0]), 64'(LAT + 1));
      check("stream_gap_1_2", 64'(tout[2] - tout[1]), 64'(LAT + 1));
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("stream_drained", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b0;

    // Config write during RUN is dropped.
    v = rand_vec();
    old_res = model(v);
    accept(v);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("cfg_ready_in_run", 64'(bus.cfg_ready), 64'd0);
    check("busy_mid_run",     64'(bus.busy),      64'd1);
    bus.cfg_we = 1'b1; bus.cfg_idx = 3'd7; bus.cfg_tt = ~tt_m[7];
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
    wait_out("cfg_dropped_in_run", old_res, 3);
    consume();
    accept(v);
    wait_out("table_unchanged", old_res, 0);
    consume();

    // Reset mid-RUN aborts and wipes the tables.
    accept(v);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrun_rst_busy",      64'(bus.busy),      64'd0);
    check("midrun_rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("midrun_rst_cfg_ready", 64'(bus.cfg_ready), 64'd1);
    check("midrun_rst_out_bits",  64'(bus.out_bits),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) tt_m[k] = '0;
    accept(v);
    wait_out("after_reset_tables_zero", model(v), 0);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
